// File: rtl/phase_detector_pkg.sv
// ---------------------------------------------------------------------------
// phase_detector_pkg
// Shared definitions for the oscillator phase readout:
//   pd_state_e  - measurement FSM states (idle / tracking / locked)
//   PD_PERIOD   - default oscillation period in clk cycles (16-stage waveform)
//   PD_PW       - default phase width, log2(PD_PERIOD)
//   PD_LOCK_CNT - default number of identical measurements needed for lock
// ---------------------------------------------------------------------------
package phase_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } pd_state_e;

  localparam int PD_PERIOD   = 16;
  localparam int PD_PW       = 4;
  localparam int PD_LOCK_CNT = 3;

endpackage

// File: rtl/phase_detector_edge_rise.sv
// ---------------------------------------------------------------------------
// phase_detector_edge_rise
// Registered rising-edge detector (the edge_rise block). The input is already
// in the clk domain, so it is only delayed once; the rise flag is high in the
// cycle where the input is first sampled high.
// Ports:
//   clk     - system clock
//   re      - synchronous active-high reset (clears the delayed copy)
//   i_sig   - input level
//   o_rise  - i_sig & ~delayed(i_sig)
// ---------------------------------------------------------------------------
module phase_detector_edge_rise (
  input  logic clk,
  input  logic re,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_d;

  // Delayed copy of the input for edge comparison
  always_ff @(posedge clk) begin
    if (re) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/phase_detector.sv
// ---------------------------------------------------------------------------
// phase_detector
// Measures how many clk cycles a neuron's rising edge lags the phase-0
// reference rising edge, and tracks stability of that measurement.
// Ports:
//   clk, re       - clock, synchronous active-high reset
//   ref_in        - reference oscillator (phase 0), clk domain
//   nin           - neuron oscillator, clk domain
//   phase_out     - last accepted phase measurement
//   phase_valid   - one-cycle pulse when phase_out updates
//   lock          - LOCK_CNT consecutive identical measurements seen
//   no_osc        - no nin rise for at least 2*PERIOD cycles
//   ref_err       - one-cycle pulse on a reference period != PERIOD
// ---------------------------------------------------------------------------
module phase_detector
  import phase_detector_pkg::*;
#(
  parameter int PERIOD   = PD_PERIOD,
  parameter int PW       = PD_PW,
  parameter int LOCK_CNT = PD_LOCK_CNT
) (
  input  logic          clk,
  input  logic          re,
  input  logic          ref_in,
  input  logic          nin,
  output logic [PW-1:0] phase_out,
  output logic          phase_valid,
  output logic          lock,
  output logic          no_osc,
  output logic          ref_err
);

  localparam logic [PW:0]   REL_MAX    = {(PW+1){1'b1}};
  localparam logic [PW:0]   REL_PERIOD = (PW+1)'(PERIOD);
  localparam logic [PW:0]   REL_LAST   = (PW+1)'(PERIOD - 1);
  localparam logic [PW+1:0] GAP_MAX    = (PW+2)'(2 * PERIOD);
  localparam logic [3:0]    CNT_MAX    = 4'(LOCK_CNT);

  logic            w_ref_rise;
  logic            w_nin_rise;
  logic            w_active;
  logic [PW:0]     w_cur;
  logic [PW+1:0]   w_gap_nxt;
  logic            w_meas;
  logic            w_accept;
  logic            w_discard;
  logic            w_same;
  logic            w_ref_err;
  logic            w_no_osc_set;
  logic            w_break;
  logic [3:0]      w_cnt_nxt;
  pd_state_e       w_state_nxt;

  logic [PW:0]     r_rel;
  logic [PW+1:0]   r_gap;
  logic [3:0]      r_cnt;
  pd_state_e       r_state;
  logic [PW-1:0]   r_phase_out;
  logic            r_phase_valid;
  logic            r_lock;
  logic            r_no_osc;
  logic            r_ref_err;

  phase_detector_edge_rise u_ref_edge (
    .clk    (clk),
    .re     (re),
    .i_sig  (ref_in),
    .o_rise (w_ref_rise)
  );

  phase_detector_edge_rise u_nin_edge (
    .clk    (clk),
    .re     (re),
    .i_sig  (nin),
    .o_rise (w_nin_rise)
  );

  // Counter next values, measurement qualification, match count and next state
  always_comb begin
    w_active = (r_state != ST_IDLE);

    // cur is the lag of "now" behind the latest reference edge; a reference
    // edge in this very cycle means lag 0 (simultaneous edges measure 0)
    if (w_ref_rise) begin
      w_cur = (PW+1)'(0);
    end else if (r_rel == REL_MAX) begin
      w_cur = REL_MAX;
    end else begin
      w_cur = r_rel + (PW+1)'(1);
    end

    if (!w_active || w_nin_rise) begin
      w_gap_nxt = (PW+2)'(0);
    end else if (r_gap == GAP_MAX) begin
      w_gap_nxt = GAP_MAX;
    end else begin
      w_gap_nxt = r_gap + (PW+2)'(1);
    end

    w_meas       = w_active & w_nin_rise;
    w_accept     = w_meas & (w_cur < REL_PERIOD);
    w_discard    = w_meas & ~(w_cur < REL_PERIOD);
    w_same       = (w_cur[PW-1:0] == r_phase_out);
    w_ref_err    = w_active & w_ref_rise & (r_rel != REL_LAST);
    // Only the transition into no_osc counts as an event
    w_no_osc_set = w_active & ~w_nin_rise & (w_gap_nxt == GAP_MAX) & ~r_no_osc;

    if (w_ref_err || w_no_osc_set) begin
      w_cnt_nxt = 4'd0;
    end else if (w_accept) begin
      if (!w_same) begin
        w_cnt_nxt = 4'd1;
      end else if (r_cnt < CNT_MAX) begin
        w_cnt_nxt = r_cnt + 4'd1;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else if (w_discard) begin
      w_cnt_nxt = 4'd0;
    end else begin
      w_cnt_nxt = r_cnt;
    end

    w_break = (w_accept & ~w_same) | w_discard | w_no_osc_set | w_ref_err;

    case (r_state)
      ST_IDLE: begin
        if (w_ref_rise) begin
          w_state_nxt = ST_TRACK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_TRACK: begin
        if (w_accept && (w_cnt_nxt == CNT_MAX)) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_TRACK;
        end
      end
      ST_LOCKED: begin
        if (w_break) begin
          w_state_nxt = ST_TRACK;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (re) begin
      r_rel         <= (PW+1)'(0);
      r_gap         <= (PW+2)'(0);
      r_cnt         <= 4'd0;
      r_state       <= ST_IDLE;
      r_phase_out   <= PW'(0);
      r_phase_valid <= 1'b0;
      r_lock        <= 1'b0;
      r_no_osc      <= 1'b0;
      r_ref_err     <= 1'b0;
    end else begin
      r_rel         <= w_cur;
      r_gap         <= w_gap_nxt;
      r_cnt         <= w_cnt_nxt;
      r_state       <= w_state_nxt;
      r_phase_valid <= w_accept;
      r_ref_err     <= w_ref_err;
      r_lock        <= (w_state_nxt == ST_LOCKED);
      if (w_accept) begin
        r_phase_out <= w_cur[PW-1:0];
      end else begin
        r_phase_out <= r_phase_out;
      end
      if (!w_active || w_nin_rise) begin
        r_no_osc <= 1'b0;
      end else if (w_no_osc_set) begin
        r_no_osc <= 1'b1;
      end else begin
        r_no_osc <= r_no_osc;
      end
    end
  end

  assign phase_out   = r_phase_out;
  assign phase_valid = r_phase_valid;
  assign lock        = r_lock;
  assign no_osc      = r_no_osc;
  assign ref_err     = r_ref_err;

endmodule
